// File: rtl/ascon_enc_input_loader_if.sv
// Byte-stream and core-facing signal bundle for the Ascon encryption input loader.
// The slave modport is the loader; the master modport is everything around it
// (upstream byte source plus the encryption core).
interface ascon_enc_input_loader_if #(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40
);

  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;

  logic [K-1:0]   key;
  logic [127:0]   nonce;
  logic [L-1:0]   associated_data;
  logic [Y-1:0]   plain_text;
  logic           encryption_start;
  logic           encryption_ready;

  logic         busy;
  logic         frame_err;

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready,
    output key,
    output nonce,
    output associated_data,
    output plain_text,
    output encryption_start,
    input  encryption_ready,
    output busy,
    output frame_err
  );

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready,
    input  key,
    input  nonce,
    input  associated_data,
    input  plain_text,
    input  encryption_start,
    output encryption_ready,
    input  busy,
    input  frame_err
  );

endinterface

// File: rtl/ascon_enc_input_loader.sv
// Front-end for the Ascon encryption core: packs a framed byte stream
// (key, nonce, AD, PT) into the core's wide inputs, holds them for the whole
// operation, and issues the start pulse sequence the core needs.
//
// state | meaning
// ------+-------------------------------------------------------------
// LOAD  | accepting bytes; frame shift register may change
// KICK  | start pulse that returns a finished core from DONE to IDLE
// FIRE  | start pulse that launches the core from IDLE
// WAIT  | core running; inputs frozen until encryption_ready
module ascon_enc_input_loader #(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  ascon_enc_input_loader_if.slave     bus
);

  localparam int N  = K + 128 + L + Y;
  localparam int NB = N / 8;
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    KICK = 2'd1,
    FIRE = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    frame_q, frame_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic            core_dirty_q, core_dirty_d;
  logic            frame_err_q, frame_err_d;
  logic            start_q, start_d;
  logic            accept;

  assign accept = bus.s_valid && (state_q == LOAD);

  // State register plus all datapath registers; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      frame_q      <= '0;
      byte_cnt_q   <= '0;
      core_dirty_q <= 1'b0;
      frame_err_q  <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      byte_cnt_q   <= byte_cnt_d;
      core_dirty_q <= core_dirty_d;
      frame_err_q  <= frame_err_d;
      start_q      <= start_d;
    end
  end

  // Next-state, byte shifting, frame checking and start-pulse generation.
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    byte_cnt_d   = byte_cnt_q;
    core_dirty_d = core_dirty_q;
    frame_err_d  = 1'b0;

    unique case (state_q)
      LOAD: begin
        if (accept) begin
          frame_d = {frame_q[N-9:0], bus.s_data};
          if (byte_cnt_q == CNT_LAST) begin
            byte_cnt_d = '0;
            if (bus.s_last) begin
              // A core that already finished must be kicked back to IDLE first.
              state_d = core_dirty_q ? KICK : FIRE;
            end else begin
              frame_err_d = 1'b1;
            end
          end else if (bus.s_last) begin
            byte_cnt_d  = '0;
            frame_err_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + CW'(1);
          end
        end
      end
      KICK: begin
        state_d = FIRE;
      end
      FIRE: begin
        core_dirty_d = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        if (bus.encryption_ready) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    // Registered so the start line is glitch-free and high exactly in KICK/FIRE.
    start_d = (state_d == KICK) || (state_d == FIRE);
  end

  assign bus.s_ready          = (state_q == LOAD);
  assign bus.busy             = (state_q != LOAD);
  assign bus.frame_err        = frame_err_q;
  assign bus.encryption_start = start_q;

  assign bus.key             = frame_q[N-1 -: K];
  assign bus.nonce           = frame_q[N-K-1 -: 128];
  assign bus.associated_data = frame_q[L+Y-1 -: L];
  assign bus.plain_text      = frame_q[Y-1:0];

endmodule

// File: tb/tb_ascon_enc_input_loader.sv
// Bench for the Ascon input loader: a small behavioural core (IDLE/RUN/DONE)
// reacts to the start pulses; expected frames go into a scoreboard when sent
// and are compared when the core starts running and when it finishes.
module tb_ascon_enc_input_loader;

  localparam int K  = 128;
  localparam int L  = 40;
  localparam int Y  = 40;
  localparam int N  = K + 128 + L + Y;
  localparam int NB = N / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascon_enc_input_loader_if #(.K(K), .L(L), .Y(Y)) bus ();

  ascon_enc_input_loader #(.K(K), .L(L), .Y(Y)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0] frame;
    int           pulses;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag, input exp_t e);
    check_val({tag, "_key"},   bus.key,             e.frame[N-1 -: K]);
    check_val({tag, "_nonce"}, bus.nonce,           e.frame[N-K-1 -: 128]);
    check_val({tag, "_ad"},    bus.associated_data, e.frame[L+Y-1 -: L]);
    check_val({tag, "_pt"},    bus.plain_text,      e.frame[Y-1:0]);
  endtask

  // Behavioural core: a start in IDLE runs for 8 cycles into DONE; a start in DONE returns to IDLE.
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_DONE} core_t;
  core_t core_st, prev_core;
  int    core_cnt;
  int    tags = 0;

  always @(posedge clk) begin
    if (rst) begin
      core_st  <= C_IDLE;
      core_cnt <= 0;
    end else begin
      case (core_st)
        C_IDLE: if (bus.encryption_start) begin core_st <= C_RUN; core_cnt <= 8; end
        C_RUN: begin
          core_cnt <= core_cnt - 1;
          if (core_cnt == 1) begin core_st <= C_DONE; tags <= tags + 1; end
        end
        default: if (bus.encryption_start) core_st <= C_IDLE;
      endcase
    end
  end

  assign bus.encryption_ready = (core_st == C_DONE);

  // Monitor: pulse-run lengths, error pulses, stray accepts, scoreboard compares.
  int run_len = 0, start_cycles = 0, err_cnt = 0, acc_run = 0;
  bit chk_next = 0;

  always @(negedge clk) begin
    if (rst) begin
      run_len   = 0;
      prev_core = C_IDLE;
      chk_next  = 0;
    end else begin
      if (bus.encryption_start) begin run_len++; start_cycles++; end
      if (bus.frame_err) err_cnt++;
      if (bus.s_valid && bus.s_ready && core_st == C_RUN) acc_run++;
      if (core_st == C_RUN && prev_core != C_RUN) begin
        if (sb.size() == 0) begin
          check_val("sb_unexpected_run", 1, 0);
        end else begin
          cur = sb.pop_front();
          check_fields("run", cur);
          check_val("pulses", run_len, cur.pulses);
        end
        run_len = 0;
      end else if (core_st == C_DONE && prev_core != C_DONE) begin
        check_fields("done", cur);
        check_val("busy_at_ready", bus.busy, 1);
        check_val("sready_at_ready", bus.s_ready, 0);
        chk_next = 1;
      end else if (chk_next) begin
        check_val("busy_after_ready", bus.busy, 0);
        check_val("sready_after_ready", bus.s_ready, 1);
        chk_next = 0;
      end
      prev_core = core_st;
    end
  end

  task automatic send_frame(input logic [7:0] base, input int nbytes, input int last_at,
                            input bit rand_v, input bit good, input int pulses);
    logic [N-1:0] e;
    logic [7:0]   b;
    bit           done;
    exp_t         x;
    e = '0;
    for (int i = 0; i < nbytes; i++) begin
      b    = base + 8'(i);
      e    = {e[N-9:0], b};
      done = 0;
      for (int t = 0; t < 1000 && !done; t++) begin
        @(negedge clk);
        bus.s_data  = b;
        bus.s_valid = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.s_last  = bus.s_valid ? (i == last_at) : 1'($urandom_range(0, 1));
        done = bus.s_valid && bus.s_ready;
      end
      if (!done) check_val("send_timeout", 0, 1);
    end
    if (good) begin
      x.frame  = e;
      x.pulses = pulses;
      sb.push_back(x);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (good) check_val("start_latency", bus.encryption_start, 1);
  endtask

  task automatic wait_done(input bit garbage);
    bit done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (core_st == C_DONE && !bus.busy) begin
        done = 1;
        bus.s_valid = 1'b0;
      end else if (garbage) begin
        if (bus.encryption_ready) begin
          bus.s_valid = 1'b0;
        end else begin
          bus.s_valid = 1'b1;
          bus.s_data  = 8'($urandom);
          bus.s_last  = 1'($urandom_range(0, 1));
        end
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!done) check_val("done_timeout", 0, 1);
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  int e0, s0, t0, a0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_sready", bus.s_ready, 1);
    check_val("rst_busy",   bus.busy, 0);
    check_val("rst_start",  bus.encryption_start, 0);
    check_val("rst_err",    bus.frame_err, 0);
    check_val("rst_key",    bus.key, 0);

    // 1: clean core, single pulse, known byte pattern
    send_frame(8'h00, NB, NB - 1, 0, 1, 1);
    wait_done(0);
    check_val("s1_key",   bus.key,   128'h000102030405060708090a0b0c0d0e0f);
    check_val("s1_nonce", bus.nonce, 128'h101112131415161718191a1b1c1d1e1f);
    check_val("s1_ad",    bus.associated_data, 40'h2021222324);
    check_val("s1_pt",    bus.plain_text,      40'h2526272829);

    // 2: core left in DONE, needs the extra kick pulse
    t0 = tags;
    send_frame(8'h40, NB, NB - 1, 0, 1, 2);
    wait_done(0);
    check_val("s2_new_tag", tags - t0, 1);

    // 3: short frame after a fresh reset, then a good frame with one pulse
    pulse_reset(2);
    @(negedge clk);
    e0 = err_cnt; s0 = start_cycles;
    send_frame(8'h80, 11, 10, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_val("s3_err_pulses", err_cnt - e0, 1);
    check_val("s3_no_start",   start_cycles - s0, 0);
    send_frame(8'h90, NB, NB - 1, 0, 1, 1);
    wait_done(0);

    // 4: full length frame missing s_last
    e0 = err_cnt; s0 = start_cycles;
    send_frame(8'hA0, NB, -1, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_val("s4_err_pulses", err_cnt - e0, 1);
    check_val("s4_no_start",   start_cycles - s0, 0);

    // 5: gappy valid, garbage offered while busy; counter must have restarted after 4
    a0 = acc_run;
    send_frame(8'h00, NB, NB - 1, 1, 1, 2);
    wait_done(1);
    check_val("s5_no_accept_busy", acc_run - a0, 0);
    check_val("s5_key", bus.key, 128'h000102030405060708090a0b0c0d0e0f);
    check_val("s5_pt",  bus.plain_text, 40'h2526272829);

    // 6: reset in the middle of WAIT, next launch single pulse
    send_frame(8'hC0, NB, NB - 1, 0, 1, 2);
    repeat (4) @(negedge clk);
    check_val("s6_in_wait", bus.busy, 1);
    pulse_reset(1);
    @(negedge clk);
    check_val("s6_key",    bus.key, 0);
    check_val("s6_nonce",  bus.nonce, 0);
    check_val("s6_ad",     bus.associated_data, 0);
    check_val("s6_pt",     bus.plain_text, 0);
    check_val("s6_start",  bus.encryption_start, 0);
    check_val("s6_busy",   bus.busy, 0);
    check_val("s6_sready", bus.s_ready, 1);
    t0 = tags;
    send_frame(8'h10, NB, NB - 1, 0, 1, 1);
    wait_done(0);
    check_val("s6_new_tag", tags - t0, 1);

    repeat (3) @(negedge clk);
    check_val("sb_leftover", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
